// File: rtl/b2h_lane_arbiter_if.sv
// Handshake bundle between the breakout-to-host lane arbiter, its three requesters and the serializer.
// The slave modport is the arbiter side; the master modport is the requester/serializer side.
interface b2h_lane_arbiter_if #(
    parameter int WORD_W = 12
);
    logic              i_lane_ready;
    logic [2:0]        i_req_valid;
    logic [WORD_W-1:0] i_req0_data;
    logic [WORD_W-1:0] i_req1_data;
    logic [WORD_W-1:0] i_req2_data;
    logic [2:0]        o_req_ready;
    logic [WORD_W-1:0] o_word;
    logic [1:0]        o_tag;
    logic              o_word_valid;
    logic [15:0]       o_starve_cnt;

    modport slave (
        input  i_lane_ready,
        input  i_req_valid,
        input  i_req0_data,
        input  i_req1_data,
        input  i_req2_data,
        output o_req_ready,
        output o_word,
        output o_tag,
        output o_word_valid,
        output o_starve_cnt
    );

    modport master (
        output i_lane_ready,
        output i_req_valid,
        output i_req0_data,
        output i_req1_data,
        output i_req2_data,
        input  o_req_ready,
        input  o_word,
        input  o_tag,
        input  o_word_valid,
        input  o_starve_cnt
    );
endinterface

// File: rtl/b2h_lane_arbiter.sv
// Shares one breakout-to-host lane between ch0 (DI samples), ch1 (power/button) and ch2 (Harp time).
// Optional macro B2H_ARB_CHANGE_ONLY_EN: ch1 is sent only when its data changes or the refresh interval expires.
module b2h_lane_arbiter #(
    parameter int                WORD_W        = 12,
    parameter int                MAX_BURST     = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD     = '0,
    parameter int                REFRESH_SLOTS = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    b2h_lane_arbiter_if.slave bus
);
    localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        GRANT_CH0  = 2'd0,
        GRANT_CH1  = 2'd1,
        GRANT_CH2  = 2'd2,
        GRANT_IDLE = 2'd3
    } grant_e;

    grant_e             grant;
    grant_e             rr_ptr;
    logic [BURST_W-1:0] burst;
    logic               ch1_eligible;
    logic [WORD_W-1:0]  sel_word;
    logic [2:0]         ready;
    logic [WORD_W-1:0]  word_q;
    logic [1:0]         tag_q;
    logic               word_valid_q;
    logic [15:0]        starve_q;

`ifdef B2H_ARB_CHANGE_ONLY_EN
    localparam int REFRESH_W = $clog2(REFRESH_SLOTS + 1);

    logic [WORD_W-1:0]    last_sent1;
    logic [REFRESH_W-1:0] refresh_cnt;

    assign ch1_eligible = bus.i_req_valid[1] &&
                          ((bus.i_req1_data != last_sent1) ||
                           (refresh_cnt >= REFRESH_W'(REFRESH_SLOTS)));

    // The granting strobe counts as the first slot of the new refresh interval.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            last_sent1  <= '0;
            refresh_cnt <= '0;
        end else if (bus.i_lane_ready) begin
            if (grant == GRANT_CH1) begin
                last_sent1  <= bus.i_req1_data;
                refresh_cnt <= REFRESH_W'(1);
            end else if (refresh_cnt < REFRESH_W'(REFRESH_SLOTS)) begin
                refresh_cnt <= refresh_cnt + REFRESH_W'(1);
            end
        end
    end
`else
    assign ch1_eligible = bus.i_req_valid[1];
`endif

    always_comb begin
        grant = GRANT_IDLE;
        if (bus.i_req_valid[0] &&
            ((burst < BURST_LIMIT) || !(ch1_eligible || bus.i_req_valid[2]))) begin
            grant = GRANT_CH0;
        end else if (ch1_eligible && bus.i_req_valid[2]) begin
            grant = rr_ptr;
        end else if (ch1_eligible) begin
            grant = GRANT_CH1;
        end else if (bus.i_req_valid[2]) begin
            grant = GRANT_CH2;
        end
    end

    always_comb begin
        ready    = 3'b000;
        sel_word = IDLE_WORD;
        case (grant)
            GRANT_CH0: begin
                ready    = 3'b001;
                sel_word = bus.i_req0_data;
            end
            GRANT_CH1: begin
                ready    = 3'b010;
                sel_word = bus.i_req1_data;
            end
            GRANT_CH2: begin
                ready    = 3'b100;
                sel_word = bus.i_req2_data;
            end
            default: begin
                ready    = 3'b000;
                sel_word = IDLE_WORD;
            end
        endcase
        if (!(bus.i_lane_ready && i_reset_n)) begin
            ready = 3'b000;
        end
    end

    // A reset cycle drops any strobe, so the slot in flight never produces a pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            word_q       <= '0;
            tag_q        <= 2'b11;
            word_valid_q <= 1'b0;
            starve_q     <= '0;
            burst        <= '0;
            rr_ptr       <= GRANT_CH1;
        end else if (bus.i_lane_ready) begin
            word_q       <= sel_word;
            tag_q        <= grant;
            word_valid_q <= 1'b1;
            case (grant)
                GRANT_CH0: begin
                    if (burst < BURST_LIMIT) begin
                        burst <= burst + BURST_W'(1);
                    end
                end
                GRANT_CH1, GRANT_CH2: begin
                    burst  <= '0;
                    rr_ptr <= (grant == GRANT_CH1) ? GRANT_CH2 : GRANT_CH1;
                    if (bus.i_req_valid[0] && (starve_q != 16'hFFFF)) begin
                        starve_q <= starve_q + 16'd1;
                    end
                end
                default: begin
                    burst <= '0;
                end
            endcase
        end else begin
            word_valid_q <= 1'b0;
        end
    end

    assign bus.o_req_ready  = ready;
    assign bus.o_word       = word_q;
    assign bus.o_tag        = tag_q;
    assign bus.o_word_valid = word_valid_q;
    assign bus.o_starve_cnt = starve_q;
endmodule

// File: tb/tb_b2h_lane_arbiter.sv
// Self-checking bench for b2h_lane_arbiter: table of slot vectors plus hand-written reset/stability sequences.
// Expected words are queued at each strobe and compared when the output pulse appears.
module tb_b2h_lane_arbiter;
    localparam int WORD_W = 12;

    typedef struct {
        logic [2:0]  valid;
        logic [11:0] d0;
        logic [11:0] d1;
        logic [11:0] d2;
        logic [1:0]  tag;
        int          starve_before;
    } vec_t;

    typedef struct {
        logic [1:0]  tag;
        logic [11:0] word;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    exp_t        sb[$];
    vec_t        vecs[$];
    exp_t        mon_e;
    logic [1:0]  hold_tag = 2'b11;
    logic [11:0] hold_word = '0;
    bit          hold_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    b2h_lane_arbiter_if #(.WORD_W(WORD_W)) bus ();

    b2h_lane_arbiter #(
        .WORD_W       (WORD_W),
        .MAX_BURST    (4),
        .IDLE_WORD    (12'h000),
        .REFRESH_SLOTS(8)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .bus      (bus)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] valid, input logic [11:0] d0, input logic [11:0] d1,
                                input logic [11:0] d2, input logic [1:0] tag, input int starve);
        vec_t v;
        v.valid = valid;
        v.d0 = d0;
        v.d1 = d1;
        v.d2 = d2;
        v.tag = tag;
        v.starve_before = starve;
        return v;
    endfunction

    // Called just after a rising edge; leaves just after the next one.
    task automatic apply_stimulus(input vec_t v);
        exp_t       e;
        logic [2:0] rdy;
        bus.i_req_valid  = v.valid;
        bus.i_req0_data  = v.d0;
        bus.i_req1_data  = v.d1;
        bus.i_req2_data  = v.d2;
        bus.i_lane_ready = 1'b1;
        e.tag = v.tag;
        case (v.tag)
            2'd0:    e.word = v.d0;
            2'd1:    e.word = v.d1;
            2'd2:    e.word = v.d2;
            default: e.word = 12'h000;
        endcase
        e.cyc = cyc;
        sb.push_back(e);
        rdy = (v.tag == 2'd3) ? 3'b000 : (3'b001 << v.tag);
        @(negedge clk);
        check_output("req_ready", bus.o_req_ready, rdy);
        check_output("starve_cnt", bus.o_starve_cnt, v.starve_before);
        @(posedge clk);
        #1;
        bus.i_lane_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic [11:0] d0);
        bus.i_lane_ready = 1'b0;
        bus.i_req0_data  = d0;
        repeat (n) begin
            @(negedge clk);
            check_output("ready_no_strobe", bus.o_req_ready, 3'b000);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        hold_en          = 1'b0;
        reset_n          = 1'b0;
        bus.i_lane_ready = 1'b1;
        bus.i_req_valid  = 3'b111;
        repeat (n) begin
            @(negedge clk);
            check_output("ready_in_reset", bus.o_req_ready, 3'b000);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_output("reset_word_valid", bus.o_word_valid, 1'b0);
        check_output("reset_tag", bus.o_tag, 2'b11);
        check_output("reset_word", bus.o_word, 12'h000);
        check_output("reset_starve", bus.o_starve_cnt, 16'd0);
        @(posedge clk);
        #1;
        reset_n          = 1'b1;
        bus.i_lane_ready = 1'b0;
        bus.i_req_valid  = 3'b000;
        hold_tag         = 2'b11;
        hold_word        = 12'h000;
        hold_en          = 1'b1;
    endtask

    // Scoreboard side: every pulse must match the oldest queued strobe, one cycle later.
    always @(negedge clk) begin
        if (bus.o_word_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse: got tag %0h word %0h, expected no pulse", bus.o_tag, bus.o_word);
            end else begin
                mon_e = sb.pop_front();
                check_output("pulse_latency", cyc, mon_e.cyc + 1);
                check_output("out_tag", bus.o_tag, mon_e.tag);
                check_output("out_word", bus.o_word, mon_e.word);
                hold_tag  = mon_e.tag;
                hold_word = mon_e.word;
            end
        end else if (hold_en) begin
            check_output("hold_tag", bus.o_tag, hold_tag);
            check_output("hold_word", bus.o_word, hold_word);
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.i_lane_ready = 1'b0;
        bus.i_req_valid  = 3'b000;
        bus.i_req0_data  = '0;
        bus.i_req1_data  = '0;
        bus.i_req2_data  = '0;

        // Idle slots.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b000, 12'h111, 12'h222, 12'h333, 2'd3, 0));
        // Burst limit with ch0 and ch1 both pending.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(3'b011, 12'h100 + 12'(i), 12'h200 + 12'(i), 12'h300,
                              (i == 4 || i == 9) ? 2'd1 : 2'd0, (i < 5) ? 0 : 1));
        end
        // Pointer now on ch2; a lone ch2 grant moves it back to ch1.
        vecs.push_back(mk(3'b100, 12'h140, 12'h240, 12'h340, 2'd2, 2));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(3'b110, 12'h150, 12'h250 + 12'(i), 12'h350 + 12'(i),
                              (i % 2 == 0) ? 2'd1 : 2'd2, 2));
        end
        vecs.push_back(mk(3'b010, 12'h160, 12'h260, 12'h360, 2'd1, 2));
        vecs.push_back(mk(3'b010, 12'h161, 12'h261, 12'h361, 2'd1, 2));
        vecs.push_back(mk(3'b110, 12'h162, 12'h262, 12'h362, 2'd2, 2));
        // ch0 alone keeps winning past the burst limit.
        for (int i = 0; i < 6; i++) vecs.push_back(mk(3'b001, 12'h170 + 12'(i), 12'h270, 12'h370, 2'd0, 2));
        vecs.push_back(mk(3'b101, 12'h180, 12'h280, 12'h380, 2'd2, 2));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(3'b111, 12'h190 + 12'(i), 12'h290, 12'h390, 2'd0, 3));
        vecs.push_back(mk(3'b111, 12'h1A0, 12'h2A0, 12'h3A0, 2'd1, 3));
        vecs.push_back(mk(3'b111, 12'h1A1, 12'h2A1, 12'h3A1, 2'd0, 4));

        @(posedge clk);
        #1;
        apply_reset(3);

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        // Stability: data wanders between strobes, output holds until the next one.
        apply_stimulus(mk(3'b001, 12'h123, 12'h000, 12'h000, 2'd0, 4));
        idle_cycles(2, 12'h456);
        apply_stimulus(mk(3'b001, 12'h789, 12'h000, 12'h000, 2'd0, 4));
        idle_cycles(1, 12'h789);

        // Reset right after a ch2 grant.
        apply_stimulus(mk(3'b100, 12'h000, 12'h000, 12'hC22, 2'd2, 4));
        apply_reset(2);
        apply_stimulus(mk(3'b110, 12'h000, 12'h0B1, 12'h0B2, 2'd1, 0));

        // Reset with pointer on ch2 and a partial burst.
        apply_stimulus(mk(3'b010, 12'h000, 12'h0C1, 12'h000, 2'd1, 0));
        apply_stimulus(mk(3'b001, 12'h0D1, 12'h000, 12'h000, 2'd0, 0));
        apply_stimulus(mk(3'b001, 12'h0D2, 12'h000, 12'h000, 2'd0, 0));
        apply_reset(1);
        for (int i = 0; i < 3; i++) apply_stimulus(mk(3'b011, 12'h0E0 + 12'(i), 12'h0F0, 12'h000, 2'd0, 0));
        apply_stimulus(mk(3'b110, 12'h000, 12'h0F1, 12'h0F2, 2'd1, 0));

`ifdef B2H_ARB_CHANGE_ONLY_EN
        // Change-only ch1: one send, seven idle slots, then the forced refresh.
        apply_stimulus(mk(3'b010, 12'h000, 12'h0A5, 12'h000, 2'd1, 0));
        for (int i = 0; i < 7; i++) apply_stimulus(mk(3'b010, 12'h000, 12'h0A5, 12'h000, 2'd3, 0));
        apply_stimulus(mk(3'b010, 12'h000, 12'h0A5, 12'h000, 2'd1, 0));
        apply_stimulus(mk(3'b010, 12'h000, 12'h0A5, 12'h000, 2'd3, 0));
        apply_stimulus(mk(3'b010, 12'h000, 12'h0A6, 12'h000, 2'd1, 0));
        apply_stimulus(mk(3'b011, 12'h0D5, 12'h0A6, 12'h000, 2'd0, 0));
`endif

        idle_cycles(3, 12'h000);
        check_output("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/b2h_lane_arbiter.md
Name: b2h_lane_arbiter

Overview:
- Shares one breakout-to-host serial data lane between three requesters:
  - ch0: digital-input samples.
  - ch1: link power and button status.
  - ch2: Harp timestamp words.
- Runs in the SYS_CLK domain, between the sources and the breakout_to_host serializer.
- Issues one word per serializer slot strobe. Each word carries a channel tag so the host can demultiplex.
- Replaces fixed lane allocation, so slow status no longer costs a full lane.

Parameters:
- WORD_W, 12, payload width of every requester and of o_word.
- MAX_BURST, 4, maximum consecutive ch0 grants while ch1 or ch2 is pending.
- IDLE_WORD, 12'h000, payload emitted on a slot with no valid requester.
- REFRESH_SLOTS, 1024, forced ch1 resend interval in slots (optional feature only).

Ports:
- i_clk, in, 1, SYS_CLK.
- i_reset_n, in, 1, synchronous active-low reset.
- i_lane_ready, in, 1, one-cycle slot strobe from the serializer.
- i_req_valid, in, 3, per-channel valid (bit n = ch n).
- i_req0_data, in, WORD_W, ch0 payload.
- i_req1_data, in, WORD_W, ch1 payload.
- i_req2_data, in, WORD_W, ch2 payload.
- o_req_ready, out, 3, per-channel ready; a transfer occurs when valid & ready.
- o_word, out, WORD_W, registered payload to the serializer.
- o_tag, out, 2, channel id of o_word; 2'b11 = idle.
- o_word_valid, out, 1, one-cycle pulse qualifying o_word/o_tag.
- o_starve_cnt, out, 16, count of slots where ch0 was denied by the burst limit; saturating.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset_n.
- Reset values:
  - o_word = 0, o_tag = 2'b11, o_word_valid = 0, o_req_ready = 0, o_starve_cnt = 0.
  - Burst counter = 0; round-robin pointer = ch1.
- Reset mid-operation: the in-flight slot is dropped with no output pulse. Strobes are ignored while i_reset_n = 0.
- Ready signalling:
  - o_req_ready is combinational: one-hot on the granted channel, and only in cycles where i_lane_ready = 1.
  - All ready bits are 0 in all other cycles.
  - Ready may depend on valid. Requesters must hold valid and data stable until the transfer.
- Grant decision, evaluated when i_lane_ready = 1:
  1. If ch0 is valid and (burst < MAX_BURST, or neither ch1 nor ch2 is valid): grant ch0; burst += 1, saturating at MAX_BURST.
  2. Otherwise, if ch1 or ch2 is valid: grant by round robin between them.
     - If only one of the two is valid, grant that one.
     - The pointer moves to the channel not just granted.
     - Burst is reset to 0.
     - If ch0 was also valid, o_starve_cnt += 1.
  3. Otherwise (no channel valid): idle slot; burst is reset to 0.
- Output timing: latency is 1 cycle. On the cycle after a strobe, o_word/o_tag take the granted data and tag (or IDLE_WORD / 2'b11), and o_word_valid = 1.
  - o_word_valid pulses after every strobe, including idle slots, so the serializer always has a word.
  - o_word/o_tag hold their value between strobes.
- Back-to-back strobes (every cycle) are legal; each produces one output word.
- A valid that asserts in the same cycle as the strobe is eligible in that cycle.
- Burst counter width is clog2(MAX_BURST+1). MAX_BURST = 0 means ch0 never wins while ch1 or ch2 is pending.

Optional Feature:
- Macro: B2H_ARB_CHANGE_ONLY_EN.
- Defined:
  - ch1 eligibility = i_req_valid[1] AND (i_req1_data != last_sent1 OR refresh_cnt >= REFRESH_SLOTS).
  - last_sent1 latches ch1 data on every ch1 transfer; its reset value is 0.
  - refresh_cnt counts strobes, saturates at REFRESH_SLOTS, and clears on a ch1 grant.
  - o_req_ready[1] is asserted only when ch1 is eligible and granted.
  - An ineligible ch1 is treated as not valid for arbitration and for starvation counting.
- Undefined: ch1 eligibility = i_req_valid[1]; last_sent1 and refresh_cnt are not built.

Test Plan:
- Idle slots: reset, then 3 strobes with no valid -> 3 pulses, each with o_tag = 3 and o_word = 12'h000; o_req_ready stays 0.
- Burst limit: MAX_BURST = 4; ch0 and ch1 held valid; 10 strobes -> tag sequence 0,0,0,0,1,0,0,0,0,1; o_starve_cnt = 2.
- Round robin: ch1 and ch2 valid, ch0 not; 4 strobes -> tags 1,2,1,2; each ready one-hot only in its strobe cycle.
- Reset mid-operation: i_reset_n low in the cycle after a ch2 grant -> no output pulse; o_tag = 3, o_word = 0; burst = 0. First grant after reset with ch1 and ch2 valid -> ch1.
- Change-only (B2H_ARB_CHANGE_ONLY_EN defined, REFRESH_SLOTS = 8): ch1 held at 12'h0A5.
  - One ch1 grant, then 7 idle-tag slots, then a forced ch1 resend on the 8th slot since that grant.
  - Changing data to 12'h0A6 -> granted on the next strobe.
- Stability: valid held with data changing between strobes -> o_word equals the data present in the strobe cycle.
